// File: rtl/lm07_spi_responder.sv
// lm07_spi_responder
// SPI temperature responder in the style of an LM07 sensor: the initiator
// selects with cs_n and clocks with sck; the block returns a 16-bit
// temperature word MSB first on sio.
//
// cs_n and sck are asynchronous to clk. Each goes through a SYNC_STAGES-deep
// synchronizer plus one history flop. Edges are found by comparing the
// synchronized level with the history flop.
//
// temp_in/temp_valid form a strobe-only interface with no back-pressure.
// temp_in is taken on every cycle where temp_valid is high. A word that
// arrives mid-frame is parked in a pending slot (the last one wins). The slot
// moves into the hold register as the FSM returns to IDLE, so a frame in
// progress never sees its source word change.
//
// The FSM state is exported on state_dbg so external checkers can bind to it.

module lm07_spi_responder #(
  parameter logic [15:0] RESET_TEMP  = 16'h041F,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cs_n,
  input  logic        sck,
  input  logic [15:0] temp_in,
  input  logic        temp_valid,
  output logic        sio,
  output logic        sio_oe,
  output logic        busy,
  output logic        frame_done,
  output logic        frame_abort,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // After reset the synchronizer chain holds forced idle levels, not the pin
  // levels. The gate below waits for the chain and the history flop to fill
  // with real pin values before any edge counts. This stops a cs_n that is
  // already low from looking like a falling edge.
  localparam logic [2:0] FLUSH_CYCLES = 3'(SYNC_STAGES + 1);

  state_t                 state;
  state_t                 state_nx;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] sck_sync;
  logic                   cs_hist;
  logic                   sck_hist;
  logic                   cs_s;
  logic                   sck_s;
  logic [2:0]             flush_cnt;
  logic                   armed;
  logic                   cs_fall;
  logic                   cs_rise;
  logic                   sck_fall;
  logic [15:0]            hold_reg;
  logic [15:0]            pend_data;
  logic                   pend_valid;
  logic [15:0]            shift_reg;
  logic [4:0]             bit_cnt;
  logic                   load_frame;
  logic                   shift_en;
  logic                   end_frame;
  logic                   ret_idle;

  assign cs_s  = cs_sync[SYNC_STAGES-1];
  assign sck_s = sck_sync[SYNC_STAGES-1];
  assign armed = (flush_cnt == FLUSH_CYCLES);

  // Synchronizers and history flops. Reset values are the idle bus levels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_sync  <= '1;
      sck_sync <= '0;
      cs_hist  <= 1'b1;
      sck_hist <= 1'b0;
    end else begin
      cs_sync  <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], sck};
      cs_hist  <= cs_s;
      sck_hist <= sck_s;
    end
  end

  // Post-reset flush counter; saturates once edge detection is armed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_cnt <= '0;
    end else if (!armed) begin
      flush_cnt <= flush_cnt + 3'd1;
    end
  end

  // Edge detection on the synchronized levels, qualified by the flush gate.
  always_comb begin
    cs_fall  = armed &  cs_hist & ~cs_s;
    cs_rise  = armed & ~cs_hist &  cs_s;
    sck_fall = armed &  sck_hist & ~sck_s;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state and datapath controls. A cs_n rise beats a coincident sck
  // fall, so the last partial bit is never shifted.
  always_comb begin
    state_nx   = state;
    load_frame = 1'b0;
    shift_en   = 1'b0;
    end_frame  = 1'b0;
    unique case (state)
      IDLE: begin
        if (cs_fall) begin
          state_nx   = SHIFT;
          load_frame = 1'b1;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_nx  = IDLE;
          end_frame = 1'b1;
        end else if (sck_fall) begin
          shift_en = 1'b1;
          if (bit_cnt == 5'd15) begin
            state_nx = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (cs_rise) begin
          state_nx  = IDLE;
          end_frame = 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign ret_idle = (state != IDLE) && (state_nx == IDLE);

  // Shift register and bit counter. In DRAIN neither moves, so bit_cnt
  // stays at 16 and the register already holds all zeros.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else if (load_frame) begin
      shift_reg <= hold_reg;
      bit_cnt   <= '0;
    end else if (shift_en) begin
      shift_reg <= {shift_reg[14:0], 1'b0};
      bit_cnt   <= bit_cnt + 5'd1;
    end
  end

  // Hold register and pending slot. A word arriving in IDLE goes straight
  // into hold. If that happens on the frame-start cycle, the frame has
  // already taken the old hold value, so the new word serves the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_reg   <= RESET_TEMP;
      pend_data  <= '0;
      pend_valid <= 1'b0;
    end else if (state == IDLE) begin
      if (temp_valid) begin
        hold_reg <= temp_in;
      end
    end else if (ret_idle) begin
      if (temp_valid) begin
        hold_reg <= temp_in;
      end else if (pend_valid) begin
        hold_reg <= pend_data;
      end
      pend_valid <= 1'b0;
    end else if (temp_valid) begin
      pend_data  <= temp_in;
      pend_valid <= 1'b1;
    end
  end

  // End-of-frame pulses: a full word (16 bits) versus a short frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      frame_done  <= end_frame && (bit_cnt == 5'd16);
      frame_abort <= end_frame && (bit_cnt != 5'd16);
    end
  end

  // Pad outputs follow the state directly, so sio_oe drops on the same
  // edge that returns the FSM to IDLE.
  always_comb begin
    sio_oe    = (state != IDLE);
    busy      = (state != IDLE);
    sio       = (state == SHIFT) ? shift_reg[15] : 1'b0;
    state_dbg = state;
  end

endmodule

// File: tb/tb_lm07_spi_responder.sv
// Self-checking bench for lm07_spi_responder.
// Before each frame, the bench predicts the expected serial bits from its own
// model of the hold register and pending slot, and pushes them onto a queue.
// When the frame ends, it pops the prediction and compares it with the bits
// captured from sio.

module tb_lm07_spi_responder;

  localparam int SYNC_STAGES = 2;
  localparam int HALF_SCK    = 10;

  // Clock and reset.
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        cs_n;
  logic        sck;
  logic [15:0] temp_in;
  logic        temp_valid;
  logic        sio;
  logic        sio_oe;
  logic        busy;
  logic        frame_done;
  logic        frame_abort;
  logic [1:0]  state_dbg;

  lm07_spi_responder #(
    .RESET_TEMP (16'h041F),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cs_n       (cs_n),
    .sck        (sck),
    .temp_in    (temp_in),
    .temp_valid (temp_valid),
    .sio        (sio),
    .sio_oe     (sio_oe),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_abort(frame_abort),
    .state_dbg  (state_dbg)
  );

  // Scoreboard state.
  logic [31:0] exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          done_cnt = 0;
  int          abort_cnt = 0;
  logic [15:0] m_hold;
  logic [15:0] m_pend;
  logic        m_pend_v;

  // Count every clock cycle in which a pulse is high.
  always @(negedge clk) begin
    if (frame_done)  done_cnt++;
    if (frame_abort) abort_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expected capture: word bits MSB first, then zeros past bit 16.
  function automatic logic [31:0] exp_bits(input logic [15:0] w, input int n);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < n; i++) begin
      r = {r[30:0], (i < 16) ? w[15-i] : 1'b0};
    end
    return r;
  endfunction

  // One full frame of nfalls sck falling edges.
  // tv_at >= 0 strobes tv_val just before that bit's fall.
  // tv_at == -1 strobes tv_val on the cycle the cs_n fall is detected.
  task automatic spi_frame(input string tag, input int nfalls, input int tv_at,
                           input logic [15:0] tv_val);
    logic [31:0] cap;
    logic [31:0] exp;
    int          d0;
    int          a0;
    cap = '0;
    d0  = done_cnt;
    a0  = abort_cnt;
    exp_q.push_back(exp_bits(m_hold, nfalls));
    cs_n = 1'b0;
    tick(SYNC_STAGES);
    check({tag, "_oe_early"}, 32'(sio_oe), 32'd0);
    if (tv_at == -1) begin
      temp_in    = tv_val;
      temp_valid = 1'b1;
      m_hold     = tv_val;
    end
    tick(1);
    temp_valid = 1'b0;
    check({tag, "_oe_lat"}, 32'(sio_oe), 32'd1);
    for (int i = 0; i < nfalls; i++) begin
      tick(2);
      cap = {cap[30:0], sio};
      if (i == tv_at) begin
        temp_in    = tv_val;
        temp_valid = 1'b1;
        m_pend     = tv_val;
        m_pend_v   = 1'b1;
        tick(1);
        temp_valid = 1'b0;
      end
      sck = 1'b1;
      tick(HALF_SCK);
      sck = 1'b0;
      tick(HALF_SCK - 2);
    end
    tick(4);
    cs_n = 1'b1;
    tick(SYNC_STAGES + 4);
    if (m_pend_v) begin
      m_hold   = m_pend;
      m_pend_v = 1'b0;
    end
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      check({tag, "_bits"}, cap, exp);
    end else begin
      check({tag, "_queue"}, 32'd0, 32'd1);
    end
    check({tag, "_done"},  32'(done_cnt - d0),  (nfalls >= 16) ? 32'd1 : 32'd0);
    check({tag, "_abort"}, 32'(abort_cnt - a0), (nfalls >= 16) ? 32'd0 : 32'd1);
    check({tag, "_oe_end"}, 32'(sio_oe), 32'd0);
  endtask

  // Main sequence.
  initial begin
    int d0;
    int a0;
    logic [15:0] rv;
    rst_n      = 1'b0;
    cs_n       = 1'b1;
    sck        = 1'b0;
    temp_in    = '0;
    temp_valid = 1'b0;
    m_hold     = 16'h041F;
    m_pend     = '0;
    m_pend_v   = 1'b0;
    tick(3);
    check("rst_sio",   32'(sio),         32'd0);
    check("rst_oe",    32'(sio_oe),      32'd0);
    check("rst_busy",  32'(busy),        32'd0);
    check("rst_done",  32'(frame_done),  32'd0);
    check("rst_abort", 32'(frame_abort), 32'd0);
    rst_n = 1'b1;
    tick(6);

    spi_frame("reset_word", 16, -2, 16'h0000);

    temp_in = 16'h241F; temp_valid = 1'b1; m_hold = 16'h241F;
    tick(1);
    temp_valid = 1'b0;
    tick(2);
    spi_frame("idle_load", 16, -2, 16'h0000);

    spi_frame("mid_update", 16, 6, 16'h311F);
    spi_frame("after_mid", 16, -2, 16'h0000);

    spi_frame("abort8", 8, -2, 16'h0000);
    spi_frame("restart", 16, -2, 16'h0000);

    spi_frame("drain20", 20, -2, 16'h0000);

    spi_frame("coincide", 16, -1, 16'hA5C3);
    spi_frame("after_coin", 16, -2, 16'h0000);

    for (int k = 0; k < 2; k++) begin
      rv = 16'($urandom_range(0, 16'hFFFF));
      temp_in = rv; temp_valid = 1'b1; m_hold = rv;
      tick(1);
      temp_valid = 1'b0;
      tick(2);
      spi_frame("rand", 16, -2, 16'h0000);
    end

    // Reset at bit 5, with a pending word parked that reset must discard.
    d0 = done_cnt;
    a0 = abort_cnt;
    cs_n = 1'b0;
    tick(SYNC_STAGES + 2);
    temp_in = 16'h5555; temp_valid = 1'b1;
    tick(1);
    temp_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sck = 1'b1;
      tick(HALF_SCK);
      sck = 1'b0;
      tick(HALF_SCK);
    end
    rst_n = 1'b0;
    #1;
    check("mrst_oe",   32'(sio_oe), 32'd0);
    check("mrst_busy", 32'(busy),   32'd0);
    check("mrst_sio",  32'(sio),    32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(12);
    check("low_cs_no_start", 32'(busy), 32'd0);
    cs_n = 1'b1;
    tick(6);
    check("mrst_pulses", 32'(done_cnt - d0 + abort_cnt - a0), 32'd0);
    m_hold   = 16'h041F;
    m_pend_v = 1'b0;
    spi_frame("post_rst", 16, -2, 16'h0000);
    spi_frame("post_rst2", 16, -2, 16'h0000);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
